// File: rtl/sine_pkg.sv
// Shared definitions for the sine generator and its sample capture FIFO:
// Avalon word addresses, CSR bit positions and the common sample width.
package sine_pkg;

   localparam int SAMPLE_W = 10;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_DATA   = 2'd2;
   localparam logic [1:0] ADDR_DECIM  = 2'd3;

   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_IRQEN_BIT = 1;
   localparam int CTRL_FLUSH_BIT = 2;
   localparam int CTRL_THR_LSB   = 8;

   localparam int STAT_EMPTY_BIT = 16;
   localparam int STAT_FULL_BIT  = 17;
   localparam int STAT_OVF_BIT   = 18;

   localparam int DATA_VALID_BIT = 31;

endpackage

// File: rtl/sine_sample_fifo_sync_fifo.sv
// Single-clock show-ahead FIFO with extended-pointer full/empty detection
// and a flush that discards everything stored, including a same-cycle push.
module sync_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic                      pop,
   input  logic                      flush,
   input  logic [DATA_W-1:0]         din,
   output logic [DATA_W-1:0]         dout,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full,
   output logic                      empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W:0]    rd_q, rd_d;
   logic [PTR_W:0]    wr_q, wr_d;
   logic              do_pop, do_push;

   // Status flags and head-of-queue view from the extended pointers.
   always_comb begin
      empty = (rd_q == wr_q);
      full  = (rd_q[PTR_W] != wr_q[PTR_W]) &&
              (rd_q[PTR_W-1:0] == wr_q[PTR_W-1:0]);
      count = wr_q - rd_q;
      dout  = mem_q[rd_q[PTR_W-1:0]];
   end

   // Pointer next-state: a pop frees a slot for a same-cycle push when full;
   // flush jumps the read pointer to the pre-push write pointer.
   always_comb begin
      do_pop  = pop & ~empty;
      do_push = push & ~flush & (~full | do_pop);
      rd_d    = rd_q;
      wr_d    = wr_q;
      if (flush) begin
         rd_d = wr_q;
      end else if (do_pop) begin
         rd_d = rd_q + PTR_ONE;
      end
      if (do_push) begin
         wr_d = wr_q + PTR_ONE;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q <= '0;
         wr_q <= '0;
      end else begin
         rd_q <= rd_d;
         wr_q <= wr_d;
      end
   end

   // Sample storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q[PTR_W-1:0]] <= din;
      end
   end

endmodule

// File: rtl/sine_sample_fifo.sv
// Capture stage for the sine generator: decimates the sample stream,
// buffers captured samples and exposes them over an Avalon-MM slave with a
// fill-level interrupt.
module sine_sample_fifo
   import sine_pkg::*;
#(
   parameter int DATA_W = SAMPLE_W,
   parameter int DEPTH  = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   input  logic              ChipSelect,
   input  logic              Read,
   input  logic              Write,
   input  logic [1:0]        Address,
   input  logic [31:0]       WriteData,
   output logic [31:0]       ReadData,
   output logic              irq
);

   localparam int PTR_W = $clog2(DEPTH);

   logic              rd_acc, wr_acc;
   logic              ctrl_wr, status_wr, decim_wr;
   logic              flush, pop, push, drop;

   logic              enable_q, enable_d;
   logic              irq_en_q, irq_en_d;
   logic [7:0]        thresh_q, thresh_d;
   logic [7:0]        decim_q, decim_d;
   logic [7:0]        dcnt_q, dcnt_d;
   logic [7:0]        n_m1;
   logic              ovf_q, ovf_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              irq_q, irq_d;

   logic [DATA_W-1:0] head;
   logic [PTR_W:0]    fifo_count;
   logic [8:0]        count9;
   logic              fifo_full, fifo_empty;
   logic              wd_unused;

   sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk   (Clk),
      .rst   (Reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (sample_data),
      .dout  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Bus decode: only ChipSelect-qualified strobes do anything.
   always_comb begin
      rd_acc    = ChipSelect & Read;
      wr_acc    = ChipSelect & Write;
      ctrl_wr   = wr_acc & (Address == ADDR_CTRL);
      status_wr = wr_acc & (Address == ADDR_STATUS);
      decim_wr  = wr_acc & (Address == ADDR_DECIM);
      flush     = ctrl_wr & WriteData[CTRL_FLUSH_BIT];
      pop       = rd_acc & (Address == ADDR_DATA);
      count9    = 9'(fifo_count);
      // Write-data bits that no register decodes.
      wd_unused = ^{WriteData[31:19], WriteData[17:16]};
   end

   // Decimator: every N-th valid sample is pushed; N=0 acts as N=1.
   always_comb begin
      n_m1   = (decim_q == 8'd0) ? 8'd0 : (decim_q - 8'd1);
      push   = enable_q & sample_valid & (dcnt_q == n_m1);
      dcnt_d = dcnt_q;
      if (!enable_q) begin
         dcnt_d = 8'd0;
      end else if (flush || decim_wr) begin
         dcnt_d = 8'd0;
      end else if (sample_valid) begin
         dcnt_d = (dcnt_q == n_m1) ? 8'd0 : (dcnt_q + 8'd1);
      end
   end

   // CSR next-state, sticky overflow and the level interrupt.
   always_comb begin
      enable_d = enable_q;
      irq_en_d = irq_en_q;
      thresh_d = thresh_q;
      decim_d  = decim_q;
      if (ctrl_wr) begin
         enable_d = WriteData[CTRL_EN_BIT];
         irq_en_d = WriteData[CTRL_IRQEN_BIT];
         thresh_d = WriteData[CTRL_THR_LSB +: 8];
      end
      if (decim_wr) begin
         decim_d = WriteData[7:0];
      end
      // A dropped sample means a push met a full FIFO with no pop or flush.
      drop  = push & fifo_full & ~pop & ~flush;
      ovf_d = ovf_q;
      if (status_wr && WriteData[STAT_OVF_BIT]) begin
         ovf_d = 1'b0;
      end
      if (drop) begin
         ovf_d = 1'b1;
      end
      irq_d = irq_en_q & (thresh_q != 8'd0) & (count9 >= {1'b0, thresh_q});
   end

   // Read mux; the result is registered, and held when there is no read.
   always_comb begin
      rdata_d = rdata_q;
      if (rd_acc) begin
         rdata_d = '0;
         case (Address)
            ADDR_CTRL: begin
               rdata_d[CTRL_EN_BIT]           = enable_q;
               rdata_d[CTRL_IRQEN_BIT]        = irq_en_q;
               rdata_d[CTRL_THR_LSB +: 8]     = thresh_q;
            end
            ADDR_STATUS: begin
               rdata_d[8:0]                   = count9;
               rdata_d[STAT_EMPTY_BIT]        = fifo_empty;
               rdata_d[STAT_FULL_BIT]         = fifo_full;
               rdata_d[STAT_OVF_BIT]          = ovf_q;
            end
            ADDR_DATA: begin
               if (!fifo_empty) begin
                  rdata_d[DATA_VALID_BIT]     = 1'b1;
                  rdata_d[DATA_W-1:0]         = head;
               end
            end
            default: begin
               rdata_d[7:0]                   = decim_q;
            end
         endcase
      end
   end

   // Control and bus-facing registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         enable_q <= 1'b0;
         irq_en_q <= 1'b0;
         thresh_q <= 8'd0;
         decim_q  <= 8'd1;
         dcnt_q   <= 8'd0;
         ovf_q    <= 1'b0;
         rdata_q  <= '0;
         irq_q    <= 1'b0;
      end else begin
         enable_q <= enable_d;
         irq_en_q <= irq_en_d;
         thresh_q <= thresh_d;
         decim_q  <= decim_d;
         dcnt_q   <= dcnt_d;
         ovf_q    <= ovf_d;
         rdata_q  <= rdata_d;
         irq_q    <= irq_d;
      end
   end

   assign ReadData = rdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_sine_sample_fifo.sv
// Testbench for sine_sample_fifo: table-driven decimation vectors, directed
// corner sequences and randomized traffic against a queue-based model.
module tb_sine_sample_fifo;

   localparam int DEPTH = 16;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        sample_valid = 1'b0;
   logic [9:0]  sample_data = '0;
   logic        ChipSelect = 1'b0;
   logic        Read = 1'b0;
   logic        Write = 1'b0;
   logic [1:0]  Address = '0;
   logic [31:0] WriteData = '0;
   logic [31:0] ReadData;
   logic        irq;

   int nchk = 0;
   int nerr = 0;

   sine_sample_fifo #(.DATA_W(10), .DEPTH(DEPTH)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .ChipSelect   (ChipSelect),
      .Read         (Read),
      .Write        (Write),
      .Address      (Address),
      .WriteData    (WriteData),
      .ReadData     (ReadData),
      .irq          (irq)
   );

   always #5 Clk = ~Clk;

   // ---------------- reference model ----------------
   logic [9:0]  mq[$];
   bit          m_en, m_irqen, m_ovf, m_irq;
   logic [7:0]  m_thr, m_decim;
   int          m_ctr;
   logic [31:0] m_rdata;

   task automatic model_reset();
      mq.delete();
      m_en = 0; m_irqen = 0; m_ovf = 0; m_irq = 0;
      m_thr = 0; m_decim = 8'd1; m_ctr = 0; m_rdata = '0;
   endtask

   task automatic model_step(input bit sv, input logic [9:0] sd, input bit rd,
                             input bit wr, input logic [1:0] addr,
                             input logic [31:0] wd);
      int  sz, neff;
      bit  pop, flush, push, drop, irq_next;
      sz   = mq.size();
      neff = (m_decim == 0) ? 1 : int'(m_decim);
      if (rd) begin
         m_rdata = '0;
         case (addr)
            2'd0: begin m_rdata[0] = m_en; m_rdata[1] = m_irqen; m_rdata[15:8] = m_thr; end
            2'd1: begin
               m_rdata[8:0] = 9'(sz);
               m_rdata[16]  = (sz == 0);
               m_rdata[17]  = (sz == DEPTH);
               m_rdata[18]  = m_ovf;
            end
            2'd2: if (sz > 0) m_rdata = 32'h8000_0000 | 32'(mq[0]);
            default: m_rdata[7:0] = m_decim;
         endcase
      end
      irq_next = m_irqen && (m_thr != 0) && (sz >= int'(m_thr));
      pop   = rd && addr == 2'd2 && sz > 0;
      flush = wr && addr == 2'd0 && wd[2];
      push  = m_en && sv && (m_ctr == neff - 1);
      if (!m_en) m_ctr = 0;
      else if (flush || (wr && addr == 2'd3)) m_ctr = 0;
      else if (sv) m_ctr = (m_ctr == neff - 1) ? 0 : m_ctr + 1;
      drop = 0;
      if (flush) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (push) begin
            if (sz < DEPTH || pop) mq.push_back(sd);
            else drop = 1;
         end
      end
      if (wr && addr == 2'd1 && wd[18]) m_ovf = 0;
      if (drop) m_ovf = 1;
      if (wr && addr == 2'd0) begin m_en = wd[0]; m_irqen = wd[1]; m_thr = wd[15:8]; end
      if (wr && addr == 2'd3) m_decim = wd[7:0];
      m_irq = irq_next;
   endtask

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // One clock with the given inputs; compares bus and irq against the model.
   task automatic tick(input bit sv, input logic [9:0] sd, input bit rd, input bit wr,
                       input logic [1:0] addr, input logic [31:0] wd);
      sample_valid = sv; sample_data = sd;
      ChipSelect = rd | wr; Read = rd; Write = wr; Address = addr; WriteData = wd;
      model_step(sv, sd, rd, wr, addr, wd);
      @(posedge Clk); #1;
      sample_valid = 0; ChipSelect = 0; Read = 0; Write = 0;
      check("model_readdata", ReadData, m_rdata);
      check("model_irq", 32'(irq), 32'(m_irq));
   endtask

   task automatic idle();                               tick(0, '0, 0, 0, 2'd0, '0); endtask
   task automatic pulse(input logic [9:0] d);           tick(1, d, 0, 0, 2'd0, '0); endtask
   task automatic wreg(input logic [1:0] a, input logic [31:0] d); tick(0, '0, 0, 1, a, d); endtask
   task automatic rreg(input logic [1:0] a, input logic [31:0] exp, input string name);
      tick(0, '0, 1, 0, a, '0);
      check(name, ReadData, exp);
   endtask

   task automatic do_reset();
      Reset = 1; #1;
      check("rst_readdata", ReadData, 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      @(posedge Clk); #1;
      Reset = 0;
      model_reset();
   endtask

   typedef struct {
      bit          sv;
      logic [9:0]  sd;
      bit          rd;
      bit          wr;
      logic [1:0]  addr;
      logic [31:0] wd;
      bit          chk;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      do_reset();
      rreg(2'd0, 32'h0000_0000, "reset_ctrl");
      rreg(2'd3, 32'h0000_0001, "reset_decim");
      rreg(2'd1, 32'h0001_0000, "reset_status");

      // Decimation by 3: table of {inputs, expected read data}.
      vecs.push_back('{0, 10'h0, 0, 1, 2'd3, 32'd3, 0, 32'h0});
      vecs.push_back('{0, 10'h0, 0, 1, 2'd0, 32'd1, 0, 32'h0});
      for (int i = 1; i <= 9; i++) vecs.push_back('{1, 10'(i), 0, 0, 2'd0, 32'h0, 0, 32'h0});
      vecs.push_back('{0, 10'h0, 1, 0, 2'd1, 32'h0, 1, 32'h0000_0003});
      vecs.push_back('{0, 10'h0, 1, 0, 2'd2, 32'h0, 1, 32'h8000_0003});
      vecs.push_back('{0, 10'h0, 1, 0, 2'd2, 32'h0, 1, 32'h8000_0006});
      vecs.push_back('{0, 10'h0, 1, 0, 2'd2, 32'h0, 1, 32'h8000_0009});
      vecs.push_back('{0, 10'h0, 1, 0, 2'd2, 32'h0, 1, 32'h0000_0000});
      foreach (vecs[i]) begin
         tick(vecs[i].sv, vecs[i].sd, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd);
         if (vecs[i].chk) check($sformatf("decim_vec%0d", i), ReadData, vecs[i].exp);
      end

      // Overflow and full boundary.
      wreg(2'd3, 32'd1);
      for (int i = 0; i < 17; i++) pulse(10'h101 + 10'(i));
      rreg(2'd1, 32'h0006_0010, "ovf_full_status");
      rreg(2'd2, 32'h8000_0101, "ovf_first_sample");
      wreg(2'd1, 32'h0004_0000);
      rreg(2'd1, 32'h0000_000F, "ovf_w1c");
      pulse(10'h112);
      tick(1, 10'h113, 1, 0, 2'd2, '0);
      check("full_push_pop_data", ReadData, 32'h8000_0102);
      rreg(2'd1, 32'h0002_0010, "full_push_pop_status");
      wreg(2'd0, 32'h5);

      // Interrupt threshold 4.
      wreg(2'd0, 32'h403);
      for (int i = 0; i < 3; i++) pulse(10'h1A0 + 10'(i));
      idle();
      check("irq_below_thr", 32'(irq), 32'h0);
      pulse(10'h1A3);
      check("irq_lag", 32'(irq), 32'h0);
      idle();
      check("irq_at_thr", 32'(irq), 32'h1);
      rreg(2'd2, 32'h8000_01A0, "irq_drain_read");
      idle();
      check("irq_drain", 32'(irq), 32'h0);
      pulse(10'h1A4);
      idle();
      check("irq_reassert", 32'(irq), 32'h1);
      wreg(2'd0, 32'h401);
      idle();
      check("irq_disabled", 32'(irq), 32'h0);

      // Flush races.
      wreg(2'd0, 32'h5);
      pulse(10'h201); pulse(10'h202);
      tick(1, 10'h203, 0, 1, 2'd0, 32'h5);
      rreg(2'd1, 32'h0001_0000, "flush_push_status");
      pulse(10'h211); pulse(10'h212);
      rreg(2'd2, 32'h8000_0211, "head_before_flush");
      wreg(2'd0, 32'h5);
      rreg(2'd1, 32'h0001_0000, "flush_empty");

      // Enable gating and DECIM=0.
      pulse(10'h301); pulse(10'h302);
      wreg(2'd0, 32'h0);
      for (int i = 0; i < 10; i++) pulse(10'h310 + 10'(i));
      rreg(2'd1, 32'h0000_0002, "enable_gate");
      wreg(2'd3, 32'h0);
      wreg(2'd0, 32'h1);
      for (int i = 0; i < 3; i++) pulse(10'h320 + 10'(i));
      rreg(2'd1, 32'h0000_0005, "decim_zero");
      rreg(2'd3, 32'h0000_0000, "decim_zero_read");

      // Reset mid-operation with 5 entries and overflow set.
      for (int i = 0; i < 12; i++) pulse(10'h330 + 10'(i));
      rreg(2'd1, 32'h0006_0010, "pre_reset_full");
      for (int i = 0; i < 11; i++) tick(0, '0, 1, 0, 2'd2, '0);
      rreg(2'd1, 32'h0004_0005, "pre_reset_state");
      do_reset();
      rreg(2'd1, 32'h0001_0000, "post_reset_status");
      rreg(2'd3, 32'h0000_0001, "post_reset_decim");
      rreg(2'd0, 32'h0000_0000, "post_reset_ctrl");
      check("post_reset_irq", 32'(irq), 32'h0);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         bit          sv;
         logic [9:0]  sd;
         logic [31:0] wd;
         int          op;
         sv = bit'($urandom_range(0, 1));
         sd = 10'($urandom);
         wd = $urandom;
         op = int'($urandom_range(0, 7));
         case (op)
            3: tick(sv, sd, 1, 0, 2'($urandom_range(0, 3)), '0);
            4: tick(sv, sd, 1, 0, 2'd2, '0);
            5: begin
               wd[15:8] = 8'($urandom_range(0, 20));
               wd[2]    = ($urandom_range(0, 7) == 0);
               wd[0]    = ($urandom_range(0, 3) != 0);
               tick(sv, sd, 0, 1, 2'd0, wd);
            end
            6: begin
               wd[7:0] = 8'($urandom_range(0, 3));
               tick(sv, sd, 0, 1, 2'd3, wd);
            end
            7: tick(sv, sd, 0, 1, 2'd1, wd);
            default: tick(sv, sd, 0, 0, 2'd0, '0);
         endcase
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/sine_sample_fifo.md
Name: sine_sample_fifo

Overview:
Downstream capture stage for the sine generator's 10-bit output samples, with an Avalon-MM slave port.
- Decimates the incoming sample stream by a programmable factor.
- Buffers captured samples in a small FIFO.
- Lets the Nios/HPS drain samples over Avalon-MM, with a level-based interrupt at a programmable fill threshold.
- Sits beside the generator in the same Qsys component group, on the same Clk.

Parameters:
DATA_W, 10, sample width (matches oData_sin)
DEPTH, 16, FIFO entries; power of 2, range 4..256
PTR_W, 4, log2(DEPTH); derived, not overridden

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
sample_valid  input  1  one-Clk-cycle strobe; sample_data is valid this cycle
sample_data  input  DATA_W  sine sample
ChipSelect  input  1  Avalon slave select
Read  input  1  Avalon read
Write  input  1  Avalon write
Address  input  2  word address: 0 CTRL, 1 STATUS, 2 DATA, 3 DECIM
WriteData  input  32  Avalon write data
ReadData  output  32  Avalon read data; registered, read latency 1
irq  output  1  level interrupt

Behaviour:
Reset and clocking
- Reset (async assert, sync release in the surrounding system):
  - ReadData=0, irq=0.
  - FIFO empty; rd_ptr and wr_ptr = 0.
  - CTRL=0, DECIM=1, decim counter=0, overflow=0.
- Only Read or Write qualified by ChipSelect has any effect.

CTRL (addr 0, R/W)
- bit0 enable.
- bit1 irq_en.
- bit2 flush: write-1 action, reads 0.
- bits[15:8] threshold, 8 bits; compared zero-extended against count.

STATUS (addr 1)
- Read fields:
  - bits[8:0] count (0..DEPTH).
  - bit16 empty.
  - bit17 full.
  - bit18 overflow (sticky).
- Write bit18=1 clears overflow. All other write bits are ignored.

DATA (addr 2, read pops)
- Non-empty FIFO: ReadData = {1'b1, 21'b0, head sample}; rd_ptr increments in the accepted read cycle.
- Empty FIFO: ReadData = 0 (bit31=0); no pointer change.
- Writes are ignored.

DECIM (addr 3, R/W)
- bits[7:0] decimation factor N; N=0 is treated as 1.
- Writing DECIM clears the decim counter.

Decimation
- When enable=1 and sample_valid=1:
  - If counter == N-1: push the sample and set counter to 0.
  - Otherwise: increment counter.
- When enable=0: counter held at 0, no pushes, FIFO contents retained.

FIFO arithmetic and boundaries
- Pointers are PTR_W+1 bits. Full when MSBs differ and low bits are equal; empty when pointers are equal; count = wr_ptr - rd_ptr.
- Push when full, no pop in the same cycle: sample dropped, overflow set, pointers unchanged.
- Push and pop in the same cycle while full: both occur; count stays DEPTH; no overflow.
- Push and pop in the same cycle while empty: pop returns empty (bit31=0); the push is stored; count becomes 1.
- Flush: sets rd_ptr to wr_ptr and clears the decim counter.
- Flush in the same cycle as a push: flush wins and the sample is discarded.
- Flush in the same cycle as a DATA read: the read returns the pre-flush head.

Interrupt
- irq = irq_en & (threshold != 0) & (count >= threshold), registered, so it lags count by 1 cycle.
- There is no separate pending bit: draining the FIFO below threshold deasserts irq.

Read mux
- Registered, 1-cycle latency.
- Reads of CTRL/DECIM return the current register values, zero-filled.
- ReadData holds its last value when there is no read.

Decomposition:
- Shared package sine_pkg:
  - Address constants ADDR_CTRL/STATUS/DATA/DECIM.
  - CTRL/STATUS bit indices.
  - SAMPLE_W=10, shared with the generator.
- One sub-module: sync_fifo.
  - Parameters: DEPTH, DATA_W.
  - Ports: push, pop, flush, din, dout (show-ahead head), count, full, empty.
- The top level holds the CSRs, the decimator, overflow/irq and the read mux.

Test Plan:
- Reset mid-operation: reset with 5 entries stored and overflow set -> next cycle count=0, overflow=0, irq=0, DECIM reads 1, ReadData=0.
- Decimation: DECIM=3, enable=1, pulse sample_valid 9 times with data 0x001..0x009 -> FIFO holds 0x003, 0x006, 0x009; three DATA reads return 0x80000003, 0x80000006, 0x80000009; a fourth read returns 0x00000000.
- Overflow and full boundary: DECIM=1, push 17 samples -> count=16, full=1, overflow=1, first read gives sample 1. W1C STATUS bit18 -> overflow=0. Push and DATA read in the same cycle while full -> count stays 16, overflow stays 0.
- Interrupt: threshold=4, irq_en=1, push 3 -> irq=0; 4th push -> irq=1 one cycle later; one DATA read -> irq=0; irq_en=0 with count≥4 -> irq=0.
- Flush races: flush coincident with a push while holding 2 entries -> count=0. DATA read in the flush cycle returns the old head with bit31=1.
- Enable gating: enable=0 with 10 sample_valid pulses -> count unchanged. DECIM=0 behaves as N=1, with every pulse pushed once enabled.
